// File: rtl/inst_if_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encodings,
// the error instruction word and the width of the delay fields.
package inst_if_pkg;

  localparam int DLY_W = 4;

  typedef logic [DLY_W-1:0] dly_t;

  localparam logic [31:0] ERR_INST = 32'h0000_0000;

  // One-hot state encodings
  localparam logic [5:0] S_IDLE    = 6'b000001;
  localparam logic [5:0] S_REQ_DLY = 6'b000010;
  localparam logic [5:0] S_READ    = 6'b000100;
  localparam logic [5:0] S_CAPT    = 6'b001000;
  localparam logic [5:0] S_RSP_DLY = 6'b010000;
  localparam logic [5:0] S_RESP    = 6'b100000;

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch request/response handshake between an instruction initiator (master)
// and the memory responder (slave).
interface inst_mem_responder_if;

  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Req_Ready;
  logic [31:0] Instruction;
  logic        Inst_Valid;
  logic        Inst_Ready;

  modport master (
    output PC, Inst_Req_Valid, Inst_Ready,
    input  Inst_Req_Ready, Instruction, Inst_Valid
  );

  modport slave (
    input  PC, Inst_Req_Valid, Inst_Ready,
    output Inst_Req_Ready, Instruction, Inst_Valid
  );

endinterface

// File: rtl/imem_delay_cnt.sv
// Loadable down-counter with zero flag, shared by the request and response
// delay phases. Load has priority; decrement saturates at zero.
module imem_delay_cnt
  import inst_if_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  dly_t load_val,
  input  logic dec,
  output dly_t count,
  output logic zero
);

  // NOTE: sequential state is always updated with <= so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec && (count != '0))
      count <= count - dly_t'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/inst_mem_responder.sv
// Single-outstanding instruction fetch responder with programmable request
// and response delays in front of a word-addressed backing memory.
module inst_mem_responder
  import inst_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_mem_responder_if.slave   bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ren,
  input  logic [31:0]           mem_rdata,
  input  dly_t                  cfg_req_delay,
  input  dly_t                  cfg_resp_delay,
  output logic                  addr_err,
  output logic [31:0]           resp_cnt
);

  logic [5:0]            state, state_nx;
  logic [ADDR_WIDTH+1:0] pc_q;
  logic [31:0]           data_q;
  logic [31:0]           resp_cnt_q;
  logic                  req_ready, resp_valid, req_hs, rsp_hs, misaligned;
  logic                  cnt_load, cnt_dec, cnt_zero;
  dly_t                  cnt_val, cnt;
  logic                  unused_pc_hi;

  // Upper PC bits select nothing: fetches wrap modulo the memory size.
  assign unused_pc_hi = ^bus.PC[31:ADDR_WIDTH+2];

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign req_ready  = !rst && (((state == S_IDLE) && (cfg_req_delay == '0)) ||
                               ((state == S_REQ_DLY) && cnt_zero));
  assign resp_valid = (state == S_RESP);
  assign req_hs     = bus.Inst_Req_Valid && req_ready;
  assign rsp_hs     = resp_valid && bus.Inst_Ready;

  assign bus.Inst_Req_Ready = req_ready;
  assign bus.Inst_Valid     = resp_valid;
  assign bus.Instruction    = resp_valid ? data_q : '0;
  assign mem_ren            = (state == S_READ);
  assign mem_addr           = mem_ren ? pc_q[ADDR_WIDTH+1:2] : '0;
  assign resp_cnt           = resp_cnt_q;

  imem_delay_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nx = state;
    cnt_load = 1'b0;
    cnt_val  = cfg_req_delay;
    cnt_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.Inst_Req_Valid) begin
          if (cfg_req_delay == '0) begin
            state_nx = S_READ;
          end else begin
            cnt_load = 1'b1;
            state_nx = S_REQ_DLY;
          end
        end
      end
      S_REQ_DLY: begin
        if (!cnt_zero)                cnt_dec  = 1'b1;
        else if (bus.Inst_Req_Valid)  state_nx = S_READ;
        else                          state_nx = S_IDLE;
      end
      S_READ: state_nx = S_CAPT;
      S_CAPT: begin
        cnt_load = 1'b1;
        cnt_val  = cfg_resp_delay;
        state_nx = (cfg_resp_delay == '0) ? S_RESP : S_RSP_DLY;
      end
      S_RSP_DLY: begin
        cnt_dec = 1'b1;
        if (cnt <= dly_t'(1)) state_nx = S_RESP;
      end
      S_RESP: begin
        if (bus.Inst_Ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pc_q       <= '0;
      data_q     <= '0;
      addr_err   <= 1'b0;
      resp_cnt_q <= '0;
    end else begin
      state <= state_nx;
      if (req_hs) pc_q <= bus.PC[ADDR_WIDTH+1:0];
      // Misaligned fetches return the error word and latch the sticky flag.
      if (state == S_CAPT) begin
        data_q <= misaligned ? ERR_INST : mem_rdata;
        if (misaligned) addr_err <= 1'b1;
      end
      if (rsp_hs) resp_cnt_q <= resp_cnt_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: a word-array memory model feeds the
// DUT, expected words go through a scoreboard queue from request to response.
module tb_inst_mem_responder;
  import inst_if_pkg::*;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mem_addr;
  logic          mem_ren;
  logic [31:0]   mem_rdata;
  dly_t          cfg_req_delay, cfg_resp_delay;
  logic          addr_err;
  logic [31:0]   resp_cnt;

  inst_mem_responder_if bus ();

  inst_mem_responder #(.ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .mem_addr       (mem_addr),
    .mem_ren        (mem_ren),
    .mem_rdata      (mem_rdata),
    .cfg_req_delay  (cfg_req_delay),
    .cfg_resp_delay (cfg_resp_delay),
    .addr_err       (addr_err),
    .resp_cnt       (resp_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];

  // Data only valid the cycle after a read strobe; junk otherwise.
  always_ff @(posedge clk) mem_rdata <= mem_ren ? mem[mem_addr] : 32'hBAD0_BAD0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_cnt;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input dly_t rd, input dly_t sd, input int stall);
    int          d, t, v;
    bit          got;
    logic [31:0] want;
    @(negedge clk);
    cfg_req_delay      = rd;
    cfg_resp_delay     = sd;
    bus.PC             = pc;
    bus.Inst_Req_Valid = 1'b1;
    bus.Inst_Ready     = (stall == 0);
    d = cyc; t = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.Inst_Req_Ready) begin got = 1; t = cyc; break; end
      @(negedge clk);
      if (cyc >= d + 1) cfg_req_delay = 4'hF;
    end
    check("req_handshake_seen", 32'(got), 32'd1);
    check("req_handshake_cycle", 32'(t), 32'((rd == 0) ? d : d + 1 + int'(rd)));
    sb.push_back((pc[1:0] != 2'b00) ? ERR_INST : mem[pc[AW+1:2]]);
    if (pc[1:0] != 2'b00) exp_err = 1'b1;

    got = 0; v = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("mem_ren_timing", 32'(mem_ren), 32'(cyc == t + 1));
      check("mem_addr", 32'(mem_addr), mem_ren ? 32'(pc[AW+1:2]) : 32'd0);
      check("req_ready_busy", 32'(bus.Inst_Req_Ready), 32'd0);
      if (bus.Inst_Valid) begin got = 1; v = cyc; break; end
      check("inst_zero_when_invalid", bus.Instruction, 32'd0);
      bus.Inst_Req_Valid = 1'b0;
      bus.PC             = 32'hDEAD_BEEF;
      if (cyc >= t + 3) cfg_resp_delay = 4'hF;
    end
    check("resp_valid_seen", 32'(got), 32'd1);
    check("resp_latency", 32'(v), 32'(t + 3 + int'(sd)));

    want = (sb.size() != 0) ? sb.pop_front() : 32'hXXXX_XXXX;
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", 32'(bus.Inst_Valid), 32'd1);
      check("stall_data", bus.Instruction, want);
      check("stall_cnt", resp_cnt, exp_cnt);
      @(negedge clk);
    end
    check("resp_valid", 32'(bus.Inst_Valid), 32'd1);
    check("resp_data", bus.Instruction, want);
    bus.Inst_Ready = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 32'd1;
    check("resp_cnt", resp_cnt, exp_cnt);
    check("valid_drop", 32'(bus.Inst_Valid), 32'd0);
    check("addr_err", 32'(addr_err), 32'(exp_err));
    bus.Inst_Ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE_0000 ^ 32'(i * 7);
    mem[4] = 32'h0050_0093;
    rst = 1'b1;
    bus.PC = '0; bus.Inst_Req_Valid = 1'b0; bus.Inst_Ready = 1'b0;
    cfg_req_delay = '0; cfg_resp_delay = '0;
    exp_cnt = '0; exp_err = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.Inst_Req_Ready), 32'd0);
    check("rst_inst_valid", 32'(bus.Inst_Valid), 32'd0);
    check("rst_instruction", bus.Instruction, 32'd0);
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_resp_cnt", resp_cnt, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", 32'(bus.Inst_Req_Ready), 32'd1);

    fetch(32'h0000_0010, 4'd0, 4'd0, 0);
    check("first_count", resp_cnt, 32'd1);
    fetch(32'h0000_0020, 4'd3, 4'd2, 0);
    fetch(32'h0000_0040, 4'd0, 4'd0, 4);
    fetch(32'h0001_0004, 4'd1, 4'd1, 0);
    fetch(32'h0000_0102, 4'd0, 4'd0, 0);
    fetch(32'h0000_0008, 4'd0, 4'd3, 1);

    // Reset while waiting out the response delay abandons the fetch.
    @(negedge clk);
    cfg_req_delay = 4'd0; cfg_resp_delay = 4'd6;
    bus.PC = 32'h0000_0018; bus.Inst_Req_Valid = 1'b1; bus.Inst_Ready = 1'b1;
    #1;
    check("abandon_handshake", 32'(bus.Inst_Req_Ready), 32'd1);
    sb.push_back(mem[6]);
    @(negedge clk);
    bus.Inst_Req_Valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abandon_pre_rst_valid", 32'(bus.Inst_Valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    exp_cnt = '0; exp_err = 1'b0;
    check("abandon_rst_addr_err", 32'(addr_err), 32'd0);
    check("abandon_rst_cnt", resp_cnt, exp_cnt);
    check("abandon_rst_mem_ren", 32'(mem_ren), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("abandon_no_valid", 32'(bus.Inst_Valid), 32'd0);
    end
    check("abandon_idle_ready", 32'(bus.Inst_Req_Ready), 32'd1);
    bus.Inst_Ready = 1'b0;
    fetch(32'h0000_000C, 4'd2, 4'd0, 0);

    @(negedge clk);
    force dut.resp_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.resp_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    check("cnt_preload", resp_cnt, exp_cnt);
    fetch(32'h0000_0014, 4'd0, 4'd0, 0);
    check("cnt_wrap", resp_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
